cdb_arbiter: RTL and testbench

- Shares a single result broadcast bus (CDB) between the two execution units, rs_ex (ALU/branch) and ls_ex (load/store).
- The CDB feeds the ROB update port and any RS/LSB snoopers.
- Each requester gets a small in-order queue with a valid/ready handshake.
- One result is broadcast per cycle under round-robin arbitration. All queues are flushed on rollback.

---
 rtl/cdb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small in-order result queues (rs_ex, ls_ex) sharing one
// registered broadcast port under round-robin arbitration, flushed on ROB rollback.
module cdb_arbiter #(
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_sign,
  input  logic                rs_valid,
  output logic                rs_ready,
  input  logic [ROB_ID_W-1:0] rs_rob_id,
  input  logic [DATA_W-1:0]   rs_data,
  input  logic [ADDR_W-1:0]   rs_jump_target_pc,
  input  logic                rs_jump_sign,
  input  logic                ls_valid,
  output logic                ls_ready,
  input  logic [ROB_ID_W-1:0] ls_rob_id,
  input  logic [DATA_W-1:0]   ls_data,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [ADDR_W-1:0]   cdb_jump_target_pc,
  output logic                cdb_jump_sign,
  output logic                cdb_src
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  // rs_ex queue storage
  logic [ROB_ID_W-1:0] r_rs_id   [QDEPTH];
  logic [DATA_W-1:0]   r_rs_data [QDEPTH];
  logic [ADDR_W-1:0]   r_rs_tgt  [QDEPTH];
  logic                r_rs_sign [QDEPTH];
  logic [PW-1:0]       r_rs_rp, r_rs_wp;
  logic [CW-1:0]       r_rs_cnt;

  // ls_ex queue storage
  logic [ROB_ID_W-1:0] r_ls_id   [QDEPTH];
  logic [DATA_W-1:0]   r_ls_data [QDEPTH];
  logic [PW-1:0]       r_ls_rp, r_ls_wp;
  logic [CW-1:0]       r_ls_cnt;

  // Broadcast registers; r_last_grant: 0 = rs_ex, 1 = ls_ex
  logic                r_cdb_valid;
  logic [ROB_ID_W-1:0] r_cdb_rob_id;
  logic [DATA_W-1:0]   r_cdb_data;
  logic [ADDR_W-1:0]   r_cdb_tgt;
  logic                r_cdb_sign;
  logic                r_cdb_src;
  logic                r_last_grant;

  logic w_active;
  logic w_rs_ne, w_ls_ne;
  logic w_rs_push, w_ls_push;
  logic w_grant_rs, w_grant_ls;

  always_comb begin
    w_active   = rdy & ~rollback_sign;
    rs_ready   = w_active & (r_rs_cnt < CW'(QDEPTH));
    ls_ready   = w_active & (r_ls_cnt < CW'(QDEPTH));
    // Id 0 is handshaken but never stored
    w_rs_push  = rs_valid & rs_ready & (rs_rob_id != '0);
    w_ls_push  = ls_valid & ls_ready & (ls_rob_id != '0);
    w_rs_ne    = (r_rs_cnt != '0);
    w_ls_ne    = (r_ls_cnt != '0);
    w_grant_rs = w_active & w_rs_ne & (~w_ls_ne | r_last_grant);
    w_grant_ls = w_active & w_ls_ne & (~w_rs_ne | ~r_last_grant);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs_rp  <= '0;
      r_rs_wp  <= '0;
      r_rs_cnt <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_rs_id[i]   <= '0;
        r_rs_data[i] <= '0;
        r_rs_tgt[i]  <= '0;
        r_rs_sign[i] <= 1'b0;
      end
    end else if (rollback_sign) begin
      r_rs_rp  <= '0;
      r_rs_wp  <= '0;
      r_rs_cnt <= '0;
    end else begin
      if (w_rs_push) begin
        r_rs_id[r_rs_wp]   <= rs_rob_id;
        r_rs_data[r_rs_wp] <= rs_data;
        r_rs_tgt[r_rs_wp]  <= rs_jump_target_pc;
        r_rs_sign[r_rs_wp] <= rs_jump_sign;
        r_rs_wp            <= r_rs_wp + PW'(1);
      end
      if (w_grant_rs) begin
        r_rs_rp <= r_rs_rp + PW'(1);
      end
      r_rs_cnt <= r_rs_cnt + CW'(w_rs_push) - CW'(w_grant_rs);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ls_rp  <= '0;
      r_ls_wp  <= '0;
      r_ls_cnt <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_ls_id[i]   <= '0;
        r_ls_data[i] <= '0;
      end
    end else if (rollback_sign) begin
      r_ls_rp  <= '0;
      r_ls_wp  <= '0;
      r_ls_cnt <= '0;
    end else begin
      if (w_ls_push) begin
        r_ls_id[r_ls_wp]   <= ls_rob_id;
        r_ls_data[r_ls_wp] <= ls_data;
        r_ls_wp            <= r_ls_wp + PW'(1);
      end
      if (w_grant_ls) begin
        r_ls_rp <= r_ls_rp + PW'(1);
      end
      r_ls_cnt <= r_ls_cnt + CW'(w_ls_push) - CW'(w_grant_ls);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_data   <= '0;
      r_cdb_tgt    <= '0;
      r_cdb_sign   <= 1'b0;
      r_cdb_src    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (rollback_sign) begin
      r_cdb_valid  <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (rdy) begin
      if (w_grant_rs) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= r_rs_id[r_rs_rp];
        r_cdb_data   <= r_rs_data[r_rs_rp];
        r_cdb_tgt    <= r_rs_tgt[r_rs_rp];
        r_cdb_sign   <= r_rs_sign[r_rs_rp];
        r_cdb_src    <= 1'b0;
        r_last_grant <= 1'b0;
      end else if (w_grant_ls) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= r_ls_id[r_ls_rp];
        r_cdb_data   <= r_ls_data[r_ls_rp];
        r_cdb_tgt    <= '0;
        r_cdb_sign   <= 1'b0;
        r_cdb_src    <= 1'b1;
        r_last_grant <= 1'b1;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    cdb_valid          = r_cdb_valid;
    cdb_rob_id         = r_cdb_rob_id;
    cdb_data           = r_cdb_data;
    cdb_jump_target_pc = r_cdb_tgt;
    cdb_jump_sign      = r_cdb_sign;
    cdb_src            = r_cdb_src;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_cdb_arbiter;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        rollback_sign = 1'b0;
  logic        rs_valid = 1'b0;
  logic [3:0]  rs_rob_id = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rs_jump_target_pc = '0;
  logic        rs_jump_sign = 1'b0;
  logic        ls_valid = 1'b0;
  logic [3:0]  ls_rob_id = '0;
  logic [31:0] ls_data = '0;
  logic        rs_ready, ls_ready;
  logic        cdb_valid, cdb_jump_sign, cdb_src;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_data, cdb_jump_target_pc;

  cdb_arbiter #(
    .ROB_ID_W(4), .DATA_W(32), .ADDR_W(32), .QDEPTH(QD)
  ) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_sign(rollback_sign),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_data(rs_data),
    .rs_jump_target_pc(rs_jump_target_pc), .rs_jump_sign(rs_jump_sign),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_rob_id(ls_rob_id), .ls_data(ls_data),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_jump_target_pc(cdb_jump_target_pc), .cdb_jump_sign(cdb_jump_sign),
    .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queues plus the broadcast the ROB should see
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] d;
    logic [31:0] t;
    logic        s;
  } ent_t;

  ent_t mq_rs[$];
  ent_t mq_ls[$];
  ent_t m_e = '0;
  ent_t m_tmp;
  logic m_v = 1'b0;
  logic m_src = 1'b0;
  logic m_ls_last = 1'b1;
  bit   acc_rs, acc_ls;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq_rs.delete();
      mq_ls.delete();
      m_v = 1'b0; m_e = '0; m_src = 1'b0; m_ls_last = 1'b1;
    end else if (rollback_sign) begin
      mq_rs.delete();
      mq_ls.delete();
      m_v = 1'b0; m_ls_last = 1'b1;
    end else if (rdy) begin
      acc_rs = rs_valid && (mq_rs.size() < QD);
      acc_ls = ls_valid && (mq_ls.size() < QD);
      if (mq_rs.size() > 0 && (mq_ls.size() == 0 || m_ls_last)) begin
        m_e = mq_rs.pop_front();
        m_src = 1'b0; m_v = 1'b1; m_ls_last = 1'b0;
      end else if (mq_ls.size() > 0) begin
        m_tmp = mq_ls.pop_front();
        m_e = '{id: m_tmp.id, d: m_tmp.d, t: 32'h0, s: 1'b0};
        m_src = 1'b1; m_v = 1'b1; m_ls_last = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      if (acc_rs && rs_rob_id != 4'd0)
        mq_rs.push_back('{id: rs_rob_id, d: rs_data, t: rs_jump_target_pc, s: rs_jump_sign});
      if (acc_ls && ls_rob_id != 4'd0)
        mq_ls.push_back('{id: ls_rob_id, d: ls_data, t: 32'h0, s: 1'b0});
    end
  end

  always @(negedge clk) begin
    chk("model_valid", 64'(cdb_valid), 64'(m_v));
    chk("model_rs_ready", 64'(rs_ready),
        64'(rdy && !rollback_sign && (!rst || mq_rs.size() < QD)));
    chk("model_ls_ready", 64'(ls_ready),
        64'(rdy && !rollback_sign && (!rst || mq_ls.size() < QD)));
    chk("model_id", 64'(cdb_rob_id), 64'(m_e.id));
    chk("model_data", 64'(cdb_data), 64'(m_e.d));
    chk("model_tgt", 64'(cdb_jump_target_pc), 64'(m_e.t));
    chk("model_sign", 64'(cdb_jump_sign), 64'(m_e.s));
    chk("model_src", 64'(cdb_src), 64'(m_src));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic set_rs(input logic v, input logic [3:0] id, input logic [31:0] d,
                        input logic [31:0] t, input logic s);
    rs_valid = v; rs_rob_id = id; rs_data = d; rs_jump_target_pc = t; rs_jump_sign = s;
  endtask

  task automatic set_ls(input logic v, input logic [3:0] id, input logic [31:0] d);
    ls_valid = v; ls_rob_id = id; ls_data = d;
  endtask

  task automatic chk_cdb(input string nm, input logic v, input logic [3:0] id,
                         input logic src);
    chk({nm, "_valid"}, 64'(cdb_valid), 64'(v));
    chk({nm, "_id"}, 64'(cdb_rob_id), 64'(id));
    chk({nm, "_src"}, 64'(cdb_src), 64'(src));
  endtask

  initial begin
    bit acc;
    bit saw_full;
    #1 rst = 1'b0;
    #2;
    chk("reset_valid", 64'(cdb_valid), 64'h0);
    chk("reset_id", 64'(cdb_rob_id), 64'h0);
    chk("reset_data", 64'(cdb_data), 64'h0);
    chk("reset_tgt", 64'(cdb_jump_target_pc), 64'h0);
    chk("reset_sign_src", {62'h0, cdb_jump_sign, cdb_src}, 64'h0);
    tick();
    tick();
    rst = 1'b1;
    rdy = 1'b1;

    // Single rs result: two-edge latency, one-edge pulse
    set_rs(1'b1, 4'd3, 32'h11, 32'h100, 1'b1);
    tick();
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    chk("t1_latency_valid", 64'(cdb_valid), 64'h0);
    tick();
    chk_cdb("t1_bcast", 1'b1, 4'd3, 1'b0);
    chk("t1_data", 64'(cdb_data), 64'h11);
    chk("t1_tgt", 64'(cdb_jump_target_pc), 64'h100);
    chk("t1_sign", 64'(cdb_jump_sign), 64'h1);
    tick();
    chk_cdb("t1_after", 1'b0, 4'd3, 1'b0);

    // Both units push every cycle: round-robin interleave
    pulse_reset();
    set_rs(1'b1, 4'd1, 32'hA1, 32'h200, 1'b1);
    set_ls(1'b1, 4'd5, 32'hB5);
    tick();
    set_rs(1'b1, 4'd2, 32'hA2, 32'h204, 1'b0);
    set_ls(1'b1, 4'd6, 32'hB6);
    tick();
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    set_ls(1'b0, 4'd0, 32'h0);
    chk_cdb("t2_rs1", 1'b1, 4'd1, 1'b0);
    tick();
    chk_cdb("t2_ls5", 1'b1, 4'd5, 1'b1);
    chk("t2_ls5_tgt", 64'(cdb_jump_target_pc), 64'h0);
    chk("t2_ls5_sign", 64'(cdb_jump_sign), 64'h0);
    tick();
    chk_cdb("t2_rs2", 1'b1, 4'd2, 1'b0);
    tick();
    chk_cdb("t2_ls6", 1'b1, 4'd6, 1'b1);
    tick();
    chk("t2_idle", 64'(cdb_valid), 64'h0);

    // Backpressure: frozen with rdy=0, then queues fill under contention
    pulse_reset();
    rdy = 1'b0;
    set_rs(1'b1, 4'd1, 32'hC1, 32'h300, 1'b0);
    #1 chk("t3_ready_frozen", 64'(rs_ready), 64'h0);
    tick();
    tick();
    chk("t3_no_push_frozen", 64'(cdb_valid), 64'h0);
    rdy = 1'b1;
    set_ls(1'b1, 4'd9, 32'hD9);
    saw_full = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_rs(1'b1, 4'(k), 32'hC0 + 32'(k), 32'h300 + 32'(k), 1'b0);
      acc = 1'b0;
      for (int w = 0; w < 10 && !acc; w++) begin
        #1;
        acc = rs_ready;
        if (!rs_ready) saw_full = 1'b1;
        tick();
      end
      chk("t3_push_accepted", 64'(acc), 64'h1);
    end
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    set_ls(1'b0, 4'd0, 32'h0);
    chk("t3_full_seen", 64'(saw_full), 64'h1);
    repeat (8) tick();
    chk("t3_drained", 64'(cdb_valid), 64'h0);

    // rdy=0 freezes a pending broadcast
    pulse_reset();
    set_rs(1'b1, 4'd7, 32'h77, 32'h700, 1'b1);
    tick();
    set_rs(1'b1, 4'd8, 32'h88, 32'h800, 1'b0);
    tick();
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    chk_cdb("t4_id7", 1'b1, 4'd7, 1'b0);
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cdb("t4_frozen", 1'b1, 4'd7, 1'b0);
      chk("t4_frozen_data", 64'(cdb_data), 64'h77);
    end
    rdy = 1'b1;
    tick();
    chk_cdb("t4_id8", 1'b1, 4'd8, 1'b0);
    tick();
    chk("t4_idle", 64'(cdb_valid), 64'h0);

    // Rollback flushes queues and restores rs_ex priority
    pulse_reset();
    set_rs(1'b1, 4'd1, 32'h1, 32'h10, 1'b0);
    set_ls(1'b1, 4'd5, 32'h5);
    tick();
    set_rs(1'b1, 4'd2, 32'h2, 32'h20, 1'b0);
    set_ls(1'b1, 4'd6, 32'h6);
    tick();
    chk_cdb("t5_pre_rb", 1'b1, 4'd1, 1'b0);
    set_rs(1'b1, 4'd9, 32'h9, 32'h90, 1'b1);
    set_ls(1'b1, 4'd11, 32'hB);
    rollback_sign = 1'b1;
    #1;
    chk("t5_rs_ready_rb", 64'(rs_ready), 64'h0);
    chk("t5_ls_ready_rb", 64'(ls_ready), 64'h0);
    tick();
    rollback_sign = 1'b0;
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    set_ls(1'b0, 4'd0, 32'h0);
    chk("t5_flushed", 64'(cdb_valid), 64'h0);
    tick();
    chk("t5_empty1", 64'(cdb_valid), 64'h0);
    tick();
    chk("t5_empty2", 64'(cdb_valid), 64'h0);
    set_rs(1'b1, 4'd4, 32'h44, 32'h400, 1'b1);
    set_ls(1'b1, 4'd10, 32'hAA);
    tick();
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    set_ls(1'b0, 4'd0, 32'h0);
    chk("t5_latency", 64'(cdb_valid), 64'h0);
    tick();
    chk_cdb("t5_rs4_first", 1'b1, 4'd4, 1'b0);
    tick();
    chk_cdb("t5_ls10", 1'b1, 4'd10, 1'b1);
    tick();
    chk("t5_idle", 64'(cdb_valid), 64'h0);

    // Id 0 is handshaken but never broadcast
    set_ls(1'b1, 4'd0, 32'hFF);
    #1 chk("t6_id0_ready", 64'(ls_ready), 64'h1);
    tick();
    set_ls(1'b0, 4'd0, 32'h0);
    chk("t6_id0_nobcast1", 64'(cdb_valid), 64'h0);
    tick();
    chk("t6_id0_nobcast2", 64'(cdb_valid), 64'h0);

    // Asynchronous reset mid-burst
    set_rs(1'b1, 4'd1, 32'h1, 32'h0, 1'b0);
    tick();
    set_rs(1'b1, 4'd2, 32'h2, 32'h0, 1'b0);
    tick();
    set_rs(1'b1, 4'd3, 32'h3, 32'h0, 1'b0);
    tick();
    set_rs(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    chk_cdb("t6_burst", 1'b1, 4'd2, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", 64'(cdb_valid), 64'h0);
    chk("t6_async_id", 64'(cdb_rob_id), 64'h0);
    rst = 1'b1;
    tick();
    chk("t6_discarded1", 64'(cdb_valid), 64'h0);
    tick();
    chk("t6_discarded2", 64'(cdb_valid), 64'h0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
